// File: rtl/ahb_fifo_pkg.sv
// Shared constants and width helper for the AHB-side synchronous FIFO.
//   DEF_DATA_WIDTH : default entry width in bits
//   DEF_DEPTH      : default number of entries
//   clog2w()       : clog2 clamped to at least one bit, for pointer/count widths
package ahb_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 55;
    localparam int unsigned DEF_DEPTH      = 4;

    // Bits needed to encode values 0..n-1 (never less than one bit).
    function automatic int unsigned clog2w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ahb_fifo_slot.sv
// One FIFO storage entry: loads on load=1, resets to zero, holds otherwise.
//   clk   : clock
//   rst_n : async active-low reset (clears entry)
//   load  : write enable for this entry
//   d     : write data
//   q     : stored data
module ahb_fifo_slot #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ahb_sync_fifo.sv
// Single-clock show-ahead FIFO with sticky overflow/underflow flags.
//   fifo_clk, fifo_rst_b     : clock, async active-low reset
//   push_en, push_data       : write request and data
//   pop_en, pop_data         : read request and head-entry data (zero when empty)
//   flush                    : synchronous empty command, overrides push/pop
//   err_clr                  : synchronous clear of the sticky error flags
//   empty, full, almost_full : occupancy flags decoded from registered count
//   count                    : occupancy
//   ovf_err, udf_err         : sticky overflow / underflow flags
module ahb_sync_fifo
    import ahb_fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned DEPTH      = DEF_DEPTH,
    parameter  int unsigned AFULL_LVL  = DEPTH - 1,
    localparam int unsigned CNT_W      = clog2w(DEPTH + 1)
) (
    input  logic                  fifo_clk,
    input  logic                  fifo_rst_b,
    input  logic                  push_en,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop_en,
    output logic [DATA_WIDTH-1:0] pop_data,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [CNT_W-1:0]      count,
    output logic                  ovf_err,
    output logic                  udf_err
);

    localparam int unsigned PTR_W = clog2w(DEPTH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DEPTH-1:0]      load_en;
    logic [DATA_WIDTH-1:0] slot_q [DEPTH];

    logic push_acc;
    logic pop_acc;
    logic ovf_set;
    logic udf_set;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Flags come from the registered count only.
    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = (count >= CNT_W'(AFULL_LVL));

    // Accept decode; a full FIFO still takes a push when a pop frees a slot.
    assign pop_acc  = pop_en & ~empty & ~flush;
    assign push_acc = push_en & (~full | pop_acc) & ~flush;
    assign ovf_set  = push_en & full & ~pop_acc & ~flush;
    assign udf_set  = pop_en & empty & ~flush;

    // Storage: one slot per entry, write-enable decoded from wr_ptr.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign load_en[i] = push_acc & (wr_ptr == PTR_W'(i));

        ahb_fifo_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
            .clk   (fifo_clk),
            .rst_n (fifo_rst_b),
            .load  (load_en[i]),
            .d     (push_data),
            .q     (slot_q[i])
        );
    end

    // Show-ahead read mux, forced to zero while empty.
    assign pop_data = empty ? '0 : slot_q[rd_ptr];

    // Pointers and occupancy.
    always_ff @(posedge fifo_clk or negedge fifo_rst_b) begin
        if (!fifo_rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_acc)  rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push_acc, pop_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky errors; a fresh error beats err_clr.
    always_ff @(posedge fifo_clk or negedge fifo_rst_b) begin
        if (!fifo_rst_b) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            ovf_err <= ovf_set | (ovf_err & ~err_clr);
            udf_err <= udf_set | (udf_err & ~err_clr);
        end
    end

endmodule

// File: doc/ahb_sync_fifo.md
AHB_SYNC_FIFO -- requirements
Module: ahb_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 55, SHALL set the entry data width in bits (legal range 1..128).
REQ-002 Parameter DEPTH, default 4, SHALL set the number of entries (legal range 2..32; need not be a power of two).
REQ-003 Parameter AFULL_LVL, default DEPTH-1, SHALL set the almost-full threshold in entries (legal range 1..DEPTH).
REQ-004 fifo_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 fifo_rst_b  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 push_en  input  1  SHALL be the write request for the current cycle.
REQ-007 push_data  input  DATA_WIDTH  SHALL be the write data, sampled when a push is accepted.
REQ-008 pop_en  input  1  SHALL be the read request for the current cycle.
REQ-009 pop_data  output  DATA_WIDTH  SHALL be the show-ahead head-entry data.
REQ-010 flush  input  1  SHALL be the synchronous empty command.
REQ-011 err_clr  input  1  SHALL be the synchronous clear for the sticky error flags.
REQ-012 empty  output  1  SHALL be high when count = 0.
REQ-013 full  output  1  SHALL be high when count = DEPTH.
REQ-014 almost_full  output  1  SHALL be high when count >= AFULL_LVL.
REQ-015 count  output  CNT_W  SHALL give the occupancy, where CNT_W = clog2(DEPTH+1).
REQ-016 ovf_err  output  1  SHALL be the sticky overflow flag.
REQ-017 udf_err  output  1  SHALL be the sticky underflow flag.

Function
REQ-018 A push SHALL be accepted when push_en=1 and (full=0 or an accepted pop occurs in the same cycle).
REQ-019 A pop SHALL be accepted when pop_en=1 and empty=0.
REQ-020 An accepted push SHALL write the entry at wr_ptr and advance wr_ptr, wrapping from DEPTH-1 to 0.
REQ-021 An accepted pop SHALL advance rd_ptr, wrapping from DEPTH-1 to 0.
REQ-022 count SHALL change per cycle as follows: +1 on push only, -1 on pop only, and no change when both or neither are accepted.
REQ-023 pop_data SHALL equal entry[rd_ptr] when empty=0, and SHALL be all-zero when empty=1.
REQ-024 Latency: data pushed into an empty FIFO SHALL appear on pop_data and clear empty in the cycle after the push edge; there SHALL be no same-cycle bypass.
REQ-025 When full=1 and push_en=pop_en=1, both operations SHALL occur, count SHALL stay at DEPTH, and ovf_err SHALL NOT set.
REQ-026 When empty=1 and push_en=pop_en=1, the push SHALL be accepted, the pop SHALL be ignored, udf_err SHALL set, and count SHALL become 1.
REQ-027 A push attempted with full=1 and no accepted pop SHALL be dropped, SHALL leave entries and pointers unchanged, and SHALL set ovf_err.
REQ-028 A pop attempted with empty=1 SHALL leave the pointers unchanged and SHALL set udf_err.
REQ-029 flush=1 SHALL clear wr_ptr, rd_ptr and count at the next edge, overriding push_en and pop_en in that cycle, with no error flag set.
REQ-030 Entry contents SHALL NOT be cleared by flush.
REQ-031 err_clr=1 SHALL clear both error flags at the next edge; a new error in the same cycle SHALL win, leaving the flag set.
REQ-032 empty, full, almost_full and count SHALL be derived from registered state only, with no combinational path from push_en or pop_en.

Reset
REQ-033 While fifo_rst_b=0, outputs SHALL immediately take: empty=1, full=0, almost_full=0 (or 1 if AFULL_LVL=0 is ever permitted), count=0, pop_data=0, ovf_err=0, udf_err=0.
REQ-034 While fifo_rst_b=0, every entry, wr_ptr and rd_ptr SHALL be zero.
REQ-035 A reset asserted mid-operation SHALL discard all contents, and the FIFO SHALL be usable from the first rising edge after deassertion.

Structure
REQ-036 Package ahb_fifo_pkg SHALL hold the default DATA_WIDTH/DEPTH constants and the clog2-based pointer and count width function.
REQ-037 Each storage entry SHALL be one instance of sub-module ahb_fifo_slot, which has a load enable, an async active-low reset to zero, and hold otherwise.
REQ-038 The top level SHALL contain only the pointers, counter, flags, write-enable decode and read mux.

Verification
REQ-039 Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> count steps 1, 2, 3, and pop_data=0x11 with empty=0 one cycle after the first push.
REQ-040 DEPTH=4: fill with 1..4, then push 5 alone -> full=1, ovf_err=1, count=4; popping then returns 1, 2, 3, 4.
REQ-041 Full, then push 9 and pop in the same cycle -> count stays 4, pop_data=2, and after three more pops pop_data=9.
REQ-042 Empty, then push 0xAA and pop in the same cycle -> udf_err=1, count=1, pop_data=0xAA; then err_clr -> udf_err=0.
REQ-043 DEPTH=3: run 10 push/pop pairs with values 0..9 -> output order is preserved across pointer wrap and count never exceeds 3.
REQ-044 count=2, then flush together with push_en -> count=0, empty=1, pop_data=0; separately, assert reset with count=3 -> all outputs return to reset values asynchronously.
